// File: rtl/sht40_meas_sequencer.sv
// SHT40 periodic measure/read sequencer feeding raw words to segdisplay.
// Optional CRC-8 word validation is enabled by defining SHT40_CRC_CHECK_EN.
module sht40_meas_sequencer #(
  parameter int          PERIOD_CYCLES    = 100000000,
  parameter int          MEAS_WAIT_CYCLES = 1000000,
  parameter int          READY_HOLD       = 16,
  parameter int          MAX_RETRY        = 3,
  parameter logic [7:0]  MEAS_CMD         = 8'hFD
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  output logic        o_txn_req,
  output logic        o_txn_rd,
  output logic [7:0]  o_txn_wdata,
  input  logic        i_txn_ack,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_txn_done,
  input  logic        i_txn_nack,
  output logic [15:0] o_temp,
  output logic [15:0] o_rh,
  output logic        o_r_temp,
  output logic        o_r_rh,
  output logic        o_busy,
  output logic [7:0]  o_err_cnt
);

  localparam int TW = $clog2(PERIOD_CYCLES);
  localparam int WW = $clog2(MEAS_WAIT_CYCLES + 1);
  localparam int HW = $clog2(READY_HOLD + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] TMAX = TW'(PERIOD_CYCLES - 1);
  localparam logic [WW-1:0] WMAX = WW'(MEAS_WAIT_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(READY_HOLD - 1);
  localparam logic [RW-1:0] RLIM = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_CMD_WAIT, S_CONV,
    S_RD, S_RD_WAIT, S_CHECK, S_PUB
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    tmsb_q, tmsb_d, tlsb_q, tlsb_d;
  logic [7:0]    rmsb_q, rmsb_d, rlsb_q, rlsb_d;
  logic          req_q, req_d, rd_q, rd_d;
  logic [15:0]   temp_q, temp_d, rh_q, rh_d;
  logic          rt_q, rt_d, rr_q, rr_d;
  logic          busy_q, busy_d;
  logic [7:0]    err_q, err_d;
  logic [1:0]    err_inc;
  logic [8:0]    err_sum;
  logic          rx_take, t_ok, r_ok;
  logic [2:0]    idx_n;

`ifdef SHT40_CRC_CHECK_EN
  logic [7:0] tcrc_q, tcrc_d, rcrc_q, rcrc_d;

  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
    end
    return c;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == TMAX) ? '0 : timer_q + 1'b1;
    wait_d  = wait_q;
    hold_d  = hold_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    tmsb_d  = tmsb_q;
    tlsb_d  = tlsb_q;
    rmsb_d  = rmsb_q;
    rlsb_d  = rlsb_q;
    temp_d  = temp_q;
    rh_d    = rh_q;
    rt_d    = rt_q;
    rr_d    = rr_q;
    err_inc = 2'd0;
    t_ok    = 1'b1;
    r_ok    = 1'b1;
`ifdef SHT40_CRC_CHECK_EN
    tcrc_d  = tcrc_q;
    rcrc_d  = rcrc_q;
    t_ok    = crc8({tmsb_q, tlsb_q}) == tcrc_q;
    r_ok    = crc8({rmsb_q, rlsb_q}) == rcrc_q;
`endif
    rx_take = i_rx_valid && (idx_q < 3'd6);
    idx_n   = idx_q + {2'b00, rx_take};

    unique case (state_q)
      S_IDLE: begin
        if (i_enable && (timer_q == '0 || timer_q == TMAX)) begin
          timer_d = '0;
          retry_d = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (i_txn_ack) state_d = S_CMD_WAIT;
      end
      S_CMD_WAIT: begin
        if (i_txn_done) begin
          if (i_txn_nack) begin
            err_inc = 2'd1;
            retry_d = '0;
            state_d = S_IDLE;
          end else begin
            wait_d  = '0;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        if (wait_q == WMAX) state_d = S_RD;
        else wait_d = wait_q + 1'b1;
      end
      S_RD: begin
        if (i_txn_ack) begin
          idx_d   = '0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (rx_take) begin
          idx_d = idx_n;
          case (idx_q)
            3'd0: tmsb_d = i_rx_data;
            3'd1: tlsb_d = i_rx_data;
            3'd3: rmsb_d = i_rx_data;
            3'd4: rlsb_d = i_rx_data;
`ifdef SHT40_CRC_CHECK_EN
            3'd2: tcrc_d = i_rx_data;
            3'd5: rcrc_d = i_rx_data;
`endif
            default: ;
          endcase
        end
        if (i_txn_done) begin
          if (i_txn_nack && retry_q < RLIM) begin
            retry_d = retry_q + 1'b1;
            wait_d  = '0;
            state_d = S_CONV;
          end else if (i_txn_nack || idx_n != 3'd6) begin
            err_inc = 2'd1;
            retry_d = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (t_ok) begin
          temp_d = {tmsb_q, tlsb_q};
          rt_d   = 1'b1;
        end
        if (r_ok) begin
          rh_d = {rmsb_q, rlsb_q};
          rr_d = 1'b1;
        end
        err_inc = {1'b0, !t_ok} + {1'b0, !r_ok};
        retry_d = '0;
        hold_d  = '0;
        state_d = S_PUB;
      end
      S_PUB: begin
        if (hold_q == HMAX) begin
          rt_d    = 1'b0;
          rr_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_sum = {1'b0, err_q} + {7'd0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    req_d   = (state_d == S_CMD) || (state_d == S_RD);
    rd_d    = (state_d == S_RD);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      wait_q  <= '0;
      hold_q  <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      tmsb_q  <= '0;
      tlsb_q  <= '0;
      rmsb_q  <= '0;
      rlsb_q  <= '0;
      req_q   <= 1'b0;
      rd_q    <= 1'b0;
      temp_q  <= '0;
      rh_q    <= '0;
      rt_q    <= 1'b0;
      rr_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= '0;
`ifdef SHT40_CRC_CHECK_EN
      tcrc_q  <= '0;
      rcrc_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      tmsb_q  <= tmsb_d;
      tlsb_q  <= tlsb_d;
      rmsb_q  <= rmsb_d;
      rlsb_q  <= rlsb_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
      temp_q  <= temp_d;
      rh_q    <= rh_d;
      rt_q    <= rt_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef SHT40_CRC_CHECK_EN
      tcrc_q  <= tcrc_d;
      rcrc_q  <= rcrc_d;
`endif
    end
  end

  assign o_txn_req   = req_q;
  assign o_txn_rd    = rd_q;
  assign o_txn_wdata = MEAS_CMD;
  assign o_temp      = temp_q;
  assign o_rh        = rh_q;
  assign o_r_temp    = rt_q;
  assign o_r_rh      = rr_q;
  assign o_busy      = busy_q;
  assign o_err_cnt   = err_q;

endmodule

// File: tb/tb_sht40_meas_sequencer.sv
// Directed bench for sht40_meas_sequencer with a bus responder
// and a publish scoreboard.
module tb_sht40_meas_sequencer;

  localparam int PER  = 400;
  localparam int MW   = 20;
  localparam int RH   = 16;
  localparam int MR   = 3;
  localparam int LIM  = PER + 200;
`ifdef SHT40_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        req, rd;
  logic [7:0]  wdata;
  logic        ack = 1'b0;
  logic        rxv = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        done = 1'b0;
  logic        nack = 1'b0;
  logic [15:0] temp, rh;
  logic        rt, rr, busy;
  logic [7:0]  errc;

  typedef struct {
    logic [15:0] t;
    logic [15:0] r;
    bit          rt;
    bit          rr;
    logic [7:0]  err;
  } pub_t;

  pub_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  int   req_cyc = 0;
  int   prev_req = 0;
  int   exp_err = 0;

  sht40_meas_sequencer #(
    .PERIOD_CYCLES(PER), .MEAS_WAIT_CYCLES(MW),
    .READY_HOLD(RH), .MAX_RETRY(MR), .MEAS_CMD(8'hFD)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .o_txn_req(req), .o_txn_rd(rd), .o_txn_wdata(wdata),
    .i_txn_ack(ack), .i_rx_valid(rxv), .i_rx_data(rxd),
    .i_txn_done(done), .i_txn_nack(nack),
    .o_temp(temp), .o_rh(rh), .o_r_temp(rt), .o_r_rh(rr),
    .o_busy(busy), .o_err_cnt(errc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] crc8(input logic [15:0] w);
    logic [7:0] c;
    c = 8'hFF;
    c ^= w[15:8];
    for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    c ^= w[7:0];
    for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    return c;
  endfunction

  function automatic logic [55:0] frame(input logic [15:0] t,
                                        input logic [15:0] r);
    return {t, crc8(t), r, crc8(r), 8'hA5};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < LIM && !got; i++) begin
      @(negedge clk);
      if (req === 1'b1) got = 1'b1;
    end
  endtask

  task automatic serve_cmd();
    bit got;
    wait_req(got);
    check("cmd_req", got, 1);
    req_cyc = cyc;
    check("cmd_rd", rd, 0);
    check("cmd_wdata", wdata, 8'hFD);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("cmd_drop", req, 0);
    @(negedge clk);
    done = 1'b1;
    done_cyc = cyc + 1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic serve_rd(input logic [55:0] f, input int n,
                          input bit nk, input bit last_done);
    bit got;
    wait_req(got);
    check("rd_req", got, 1);
    check("rd_rd", rd, 1);
    check("rd_delay", cyc - done_cyc, MW);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      rxv = 1'b1;
      rxd = f[55 - 8*(i % 7) -: 8];
      if (last_done && i == n - 1) begin
        done = 1'b1;
        done_cyc = cyc + 1;
      end
      @(negedge clk);
      rxv = 1'b0;
      done = 1'b0;
    end
    if (!last_done) begin
      done = 1'b1;
      nack = nk;
      done_cyc = cyc + 1;
      @(negedge clk);
      done = 1'b0;
      nack = 1'b0;
    end
  endtask

  task automatic observe();
    pub_t        e;
    int          rtc, rrc;
    bit          fin;
    logic [15:0] t_rise, r_rise;
    e = sb.pop_front();
    rtc = 0;
    rrc = 0;
    fin = 1'b0;
    t_rise = '0;
    r_rise = '0;
    for (int i = 0; i < LIM && !fin; i++) begin
      @(negedge clk);
      if (rt) begin
        if (rtc == 0) t_rise = temp;
        rtc++;
      end
      if (rr) begin
        if (rrc == 0) r_rise = rh;
        rrc++;
      end
      if (busy === 1'b0) fin = 1'b1;
    end
    check("pub_end", fin, 1);
    check("r_temp_cycles", rtc, e.rt ? RH : 0);
    check("r_rh_cycles", rrc, e.rr ? RH : 0);
    if (e.rt) check("temp_at_rise", t_rise, e.t);
    if (e.rr) check("rh_at_rise", r_rise, e.r);
    check("temp_hold", temp, e.t);
    check("rh_hold", rh, e.r);
    check("err_cnt", errc, e.err);
  endtask

  task automatic push(input logic [15:0] t, input logic [15:0] r,
                      input bit a, input bit b);
    pub_t e;
    e.t = t;
    e.r = r;
    e.rt = a;
    e.rr = b;
    e.err = 8'(exp_err);
    sb.push_back(e);
  endtask

  initial begin
    logic [55:0] f;
    int          rel, cnt;
    bit          got;

    en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", req, 0);
    check("rst_busy", busy, 0);
    check("rst_temp", temp, 0);
    check("rst_rt", {rt, rr}, 0);
    check("rst_wdata", wdata, 8'hFD);
    rst_n = 1'b1;

    // nominal frame
    serve_cmd();
    prev_req = req_cyc;
    serve_rd({8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92, 8'h00},
             6, 1'b0, 1'b0);
    push(16'hBEEF, 16'hBEEF, 1, 1);
    observe();

    // two read NACKs, then good frame with done on the last byte
    serve_cmd();
    check("period_2", req_cyc - prev_req, PER);
    prev_req = req_cyc;
    serve_rd('0, 0, 1'b1, 1'b0);
    serve_rd('0, 0, 1'b1, 1'b0);
    serve_rd(frame(16'h1234, 16'h5678), 6, 1'b0, 1'b1);
    push(16'h1234, 16'h5678, 1, 1);
    observe();

    // three read NACKs abandon the sequence
    serve_cmd();
    check("period_3", req_cyc - prev_req, PER);
    prev_req = req_cyc;
    for (int i = 0; i < MR; i++) serve_rd('0, 0, 1'b1, 1'b0);
    exp_err++;
    push(16'h1234, 16'h5678, 0, 0);
    observe();

    // RH CRC byte wrong
    serve_cmd();
    check("period_4", req_cyc - prev_req, PER);
    prev_req = req_cyc;
    serve_rd({8'hBE, 8'hEF, 8'h92, 8'h12, 8'h34, 8'h00, 8'h00},
             6, 1'b0, 1'b0);
    exp_err += CRC_EN ? 1 : 0;
    push(16'hBEEF, CRC_EN ? 16'h5678 : 16'h1234, 1, !CRC_EN);
    observe();

    // short read
    serve_cmd();
    check("period_5", req_cyc - prev_req, PER);
    serve_rd(frame(16'hAAAA, 16'h5555), 4, 1'b0, 1'b0);
    exp_err++;
    push(16'hBEEF, CRC_EN ? 16'h5678 : 16'h1234, 0, 0);
    observe();

    // seven bytes: trailing byte ignored
    serve_cmd();
    f = frame(16'h0ABC, 16'h0DEF);
    serve_rd(f, 7, 1'b0, 1'b0);
    push(16'h0ABC, 16'h0DEF, 1, 1);
    observe();

    // reset during conversion wait
    serve_cmd();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_err", errc, 0);
    check("midrst_temp", temp, 0);
    check("midrst_rh", rh, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    serve_cmd();
    check("restart_fast", (req_cyc - rel) <= 2, 1);

    // enable dropped during conversion
    en = 1'b0;
    exp_err = 0;
    serve_rd(frame(16'h1122, 16'h3344), 6, 1'b0, 1'b0);
    push(16'h1122, 16'h3344, 1, 1);
    observe();
    cnt = 0;
    for (int i = 0; i < PER + 50; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) cnt++;
    end
    check("idle_after_disable", cnt, 0);
    wait_req(got);
    check("no_new_start", got, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
